// File: rtl/sdr_frame_pkg.sv
// rtl/sdr_frame_pkg.sv - shared types and constants for the stream framer
// Contents: framer FSM state enum, default preamble byte and sync word, CRC-8 polynomial.
// The CRC state exists only when STREAM_FRAMER_CRC_EN is defined.
package sdr_frame_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE_DEFAULT = 8'h55;
  localparam logic [15:0] SYNC_WORD_DEFAULT     = 16'hD391;
  localparam logic [7:0]  CRC8_POLY             = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SYNC     = 3'd2,
    ST_LEN      = 3'd3,
    ST_PAYLOAD  = 3'd4
`ifdef STREAM_FRAMER_CRC_EN
    , ST_CRC    = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/crc8_update.sv
// rtl/crc8_update.sv - combinational one-byte CRC-8 step (MSB first, no reflection)
// Ports:
//   crc_in  [7:0] - current CRC value
//   data_in [7:0] - byte folded into the CRC
//   crc_out [7:0] - CRC after absorbing data_in
module crc8_update
  import sdr_frame_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in ^ data_in;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/stream_framer.sv
// rtl/stream_framer.sv - wraps a payload byte stream into preamble/sync/len/payload[/crc] frames
// Optional feature macro: STREAM_FRAMER_CRC_EN (appends CRC-8 over LEN and payload bytes).
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   hdr_valid/hdr_len     - frame descriptor (payload byte count), hdr_ready accepts it
//   in_valid/in_data      - payload bytes, in_ready accepts one
//   out_valid/out_data    - registered framed byte stream, out_ready from downstream
//   out_last              - marks the final byte of each frame
//   busy                  - FSM is not idle
module stream_framer
  import sdr_frame_pkg::*;
#(
  parameter int          PREAMBLE_LEN  = 4,
  parameter logic [7:0]  PREAMBLE_BYTE = PREAMBLE_BYTE_DEFAULT,
  parameter logic [15:0] SYNC_WORD     = SYNC_WORD_DEFAULT
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hdr_valid,
  input  logic [7:0] hdr_len,
  output logic       hdr_ready,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy
);

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);

  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic [7:0] len_q;
  logic       slot_free;
  logic       hdr_fire;
  logic       emit;
  logic [7:0] emit_data;
  logic       emit_last;

`ifdef STREAM_FRAMER_CRC_EN
  logic [7:0] crc_q, crc_next;
  logic       crc_feed;
`endif

  assign slot_free = ~out_valid | out_ready;
  assign hdr_fire  = hdr_valid & hdr_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next state plus the byte (if any) pushed into the output slot this cycle.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    emit      = 1'b0;
    emit_data = 8'h00;
    emit_last = 1'b0;
`ifdef STREAM_FRAMER_CRC_EN
    crc_feed  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        // The first preamble byte leaves with the descriptor handshake so a
        // queued frame follows the previous last byte without a bubble.
        if (hdr_fire) begin
          emit      = 1'b1;
          emit_data = PREAMBLE_BYTE;
          if (PREAMBLE_LEN == 1) begin
            state_d = ST_SYNC;
            cnt_d   = 8'd0;
          end else begin
            state_d = ST_PREAMBLE;
            cnt_d   = 8'd1;
          end
        end
      end
      ST_PREAMBLE: begin
        if (slot_free) begin
          emit      = 1'b1;
          emit_data = PREAMBLE_BYTE;
          if (cnt == PRE_LAST) begin
            state_d = ST_SYNC;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt + 8'd1;
          end
        end
      end
      ST_SYNC: begin
        if (slot_free) begin
          emit = 1'b1;
          if (cnt == 8'd0) begin
            emit_data = SYNC_WORD[15:8];
            cnt_d     = 8'd1;
          end else begin
            emit_data = SYNC_WORD[7:0];
            cnt_d     = 8'd0;
            state_d   = ST_LEN;
          end
        end
      end
      ST_LEN: begin
        if (slot_free) begin
          emit      = 1'b1;
          emit_data = len_q;
`ifdef STREAM_FRAMER_CRC_EN
          crc_feed  = 1'b1;
`endif
          if (len_q != 8'd0) begin
            state_d = ST_PAYLOAD;
          end else begin
`ifdef STREAM_FRAMER_CRC_EN
            state_d   = ST_CRC;
`else
            state_d   = ST_IDLE;
            emit_last = 1'b1;
`endif
          end
        end
      end
      ST_PAYLOAD: begin
        if (in_valid && in_ready) begin
          emit      = 1'b1;
          emit_data = in_data;
`ifdef STREAM_FRAMER_CRC_EN
          crc_feed  = 1'b1;
`endif
          // len_q is nonzero here, so len_q-1 cannot underflow.
          if (cnt == len_q - 8'd1) begin
            cnt_d = 8'd0;
`ifdef STREAM_FRAMER_CRC_EN
            state_d   = ST_CRC;
`else
            state_d   = ST_IDLE;
            emit_last = 1'b1;
`endif
          end else begin
            cnt_d = cnt + 8'd1;
          end
        end
      end
`ifdef STREAM_FRAMER_CRC_EN
      ST_CRC: begin
        if (slot_free) begin
          emit      = 1'b1;
          emit_data = crc_q;
          emit_last = 1'b1;
          state_d   = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and status outputs
  always_comb begin
    hdr_ready = (state == ST_IDLE)    & slot_free & ~rst;
    in_ready  = (state == ST_PAYLOAD) & slot_free & ~rst;
    busy      = (state != ST_IDLE);
  end

  // Output slot, byte counter and latched length
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
      cnt       <= 8'd0;
      len_q     <= 8'd0;
    end else begin
      cnt <= cnt_d;
      if (hdr_fire) len_q <= hdr_len;
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= emit_data;
        out_last  <= emit_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

`ifdef STREAM_FRAMER_CRC_EN
  crc8_update u_crc8 (
    .crc_in  (crc_q),
    .data_in (emit_data),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk) begin
    if (rst)           crc_q <= 8'h00;
    else if (hdr_fire) crc_q <= 8'h00;
    else if (crc_feed) crc_q <= crc_next;
  end
`endif

endmodule
